// File: rtl/axi_wready_throttle.sv
// axi_wready_throttle
//   Inserts configurable backpressure on an AXI write-data channel and counts
//   the traffic that passes through it.
//
//   Ports
//     ACLK, ARESETN       clock, asynchronous active-low reset
//     S_WVALID, S_WLAST   upstream write-data valid / last beat
//     S_WREADY            ready to upstream  (gate & M_WREADY)
//     M_WVALID            valid to downstream (S_WVALID & gate)
//     M_WREADY            ready from downstream
//     CFG_POLICY          0/3 pass-through, 1 oscillate, 2 single-shot
//     CFG_LOW, CFG_HIGH   gate-low / gate-high cycle counts
//     CFG_LOAD            one-cycle pulse latching CFG_*
//     BEAT_CNT, BURST_CNT handshake / last-beat handshake counters (wrapping)
//     ERROR               sticky VALID-drop flag
module axi_wready_throttle #(
  parameter int CNT_W  = 8,
  parameter int STAT_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              S_WVALID,
  input  logic              S_WLAST,
  output logic              S_WREADY,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  input  logic [1:0]        CFG_POLICY,
  input  logic [CNT_W-1:0]  CFG_LOW,
  input  logic [CNT_W-1:0]  CFG_HIGH,
  input  logic              CFG_LOAD,
  output logic [STAT_W-1:0] BEAT_CNT,
  output logic [STAT_W-1:0] BURST_CNT,
  output logic              ERROR
);

  typedef enum logic [2:0] {
    ST_RST, ST_PASS, ST_LOW, ST_HIGH, ST_IDLE, ST_WAIT, ST_OPEN
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gate_q, gate_d;
  logic [1:0]         pol_q;
  logic [CNT_W-1:0]   low_q, high_q;
  logic               vld_q, hs_q;
  logic               hs;

  assign hs       = S_WVALID & gate_q & M_WREADY;
  assign S_WREADY = gate_q & M_WREADY;
  assign M_WVALID = S_WVALID & gate_q;

  // Oscillate with zero low time never visits LOW, so it enters straight at HIGH.
  function automatic state_t entry_state(input logic [1:0] pol, input logic [CNT_W-1:0] low);
    case (pol)
      2'd1:    entry_state = (low == '0) ? ST_HIGH : ST_LOW;
      2'd2:    entry_state = ST_IDLE;
      default: entry_state = ST_PASS;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CFG_LOAD) begin
      // New configuration restarts the FSM; any count in flight is dropped.
      state_d = entry_state(CFG_POLICY, CFG_LOW);
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_d = entry_state(pol_q, low_q);
          cnt_d   = '0;
        end
        ST_PASS: state_d = ST_PASS;
        ST_LOW: begin
          if (low_q == '0 || cnt_q == low_q - CNT_ONE) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q >= high_q - CNT_ONE) begin
            state_d = (low_q == '0) ? ST_HIGH : ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_IDLE: begin
          // The cycle VALID is first seen counts as t0; the gate opens LOW cycles later.
          if (S_WVALID) begin
            state_d = (low_q == '0) ? ST_OPEN : ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          if (low_q == '0 || cnt_q == low_q - CNT_ONE) begin
            state_d = ST_OPEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_OPEN: if (hs) state_d = ST_IDLE;
        default: begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end
      endcase
    end
    gate_d = (state_d == ST_PASS) || (state_d == ST_HIGH) || (state_d == ST_OPEN);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pol_q  <= 2'd0;
      low_q  <= '0;
      high_q <= CNT_ONE;
    end else if (CFG_LOAD) begin
      pol_q  <= CFG_POLICY;
      low_q  <= CFG_LOW;
      high_q <= (CFG_HIGH == '0) ? CNT_ONE : CFG_HIGH;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      BEAT_CNT  <= '0;
      BURST_CNT <= '0;
      vld_q     <= 1'b0;
      hs_q      <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      if (hs)            BEAT_CNT  <= BEAT_CNT + STAT_ONE;
      if (hs && S_WLAST) BURST_CNT <= BURST_CNT + STAT_ONE;
      vld_q <= S_WVALID;
      hs_q  <= hs;
      // VALID withdrawn before being accepted is a protocol violation.
      if (vld_q && !hs_q && !S_WVALID) ERROR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wready_throttle.sv
module tb_axi_wready_throttle;
  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              S_WVALID, S_WLAST, S_WREADY, M_WVALID, M_WREADY;
  logic [1:0]        CFG_POLICY;
  logic [CNT_W-1:0]  CFG_LOW, CFG_HIGH;
  logic              CFG_LOAD;
  logic [STAT_W-1:0] BEAT_CNT, BURST_CNT;
  logic              ERROR;

  axi_wready_throttle #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_WVALID(S_WVALID), .S_WLAST(S_WLAST),
    .S_WREADY(S_WREADY), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .CFG_POLICY(CFG_POLICY), .CFG_LOW(CFG_LOW), .CFG_HIGH(CFG_HIGH),
    .CFG_LOAD(CFG_LOAD), .BEAT_CNT(BEAT_CNT), .BURST_CNT(BURST_CNT), .ERROR(ERROR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic v, l, r;
    logic exp_sready, exp_mvalid;
  } vec_t;

  int   checks = 0, errors = 0;
  logic exp_q[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and stay for one cycle.
  task automatic cyc(input logic v, input logic l, input logic r, input logic ld,
                     input logic [1:0] pol, input logic [CNT_W-1:0] lo, input logic [CNT_W-1:0] hi);
    @(posedge ACLK); #1;
    S_WVALID = v; S_WLAST = l; M_WREADY = r;
    CFG_LOAD = ld; CFG_POLICY = pol; CFG_LOW = lo; CFG_HIGH = hi;
  endtask

  task automatic pop_chk(input string name, input logic act);
    logic e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, {31'd0, act}, {31'd0, e});
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0; S_WVALID = 0; S_WLAST = 0; M_WREADY = 0; CFG_LOAD = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    ARESETN = 1'b0; S_WVALID = 1; S_WLAST = 0; M_WREADY = 1; CFG_LOAD = 0;
    CFG_POLICY = 0; CFG_LOW = 0; CFG_HIGH = 0;
    #12;
    chk("rst_sready", {31'd0, S_WREADY}, 0);
    chk("rst_mvalid", {31'd0, M_WVALID}, 0);
    chk("rst_beat",   {16'd0, BEAT_CNT}, 0);
    chk("rst_burst",  {16'd0, BURST_CNT}, 0);
    chk("rst_error",  {31'd0, ERROR}, 0);
    @(negedge ACLK);
    S_WVALID = 0; ARESETN = 1'b1; #1;
    chk("pre_edge_sready", {31'd0, S_WREADY}, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pass_after_rst", {31'd0, S_WREADY}, 1);

    // Policy 0, M_WREADY toggling: 8 beats, last one flagged as WLAST.
    for (int i = 0; i < 16; i++) begin
      tbl[i].v = 1; tbl[i].l = (i == 15); tbl[i].r = i[0];
      tbl[i].exp_sready = i[0]; tbl[i].exp_mvalid = 1;
    end
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].l, tbl[i].r, 0, 0, 0, 0);
      exp_q.push_back(tbl[i].exp_sready);
      exp_q.push_back(tbl[i].exp_mvalid);
      @(negedge ACLK);
      pop_chk("p0_sready", S_WREADY);
      pop_chk("p0_mvalid", M_WVALID);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("p0_beat",  {16'd0, BEAT_CNT}, 8);
    chk("p0_burst", {16'd0, BURST_CNT}, 1);
    chk("p0_error", {31'd0, ERROR}, 0);

    // Load policy 1 (LOW=5, HIGH=1) on a handshake cycle: beat counted, old gate used.
    cyc(1, 0, 1, 1, 1, 5, 1);
    @(negedge ACLK);
    chk("load_hs_sready", {31'd0, S_WREADY}, 1);
    for (int k = 1; k <= 60; k++) begin
      cyc(1, 0, 1, 0, 1, 5, 1);
      exp_q.push_back((k % 6) == 0);
      @(negedge ACLK);
      pop_chk("p1_sready", S_WREADY);
    end

    // Policy 2, LOW=3: one beat every 5 cycles, 4-beat burst.
    cyc(0, 0, 1, 1, 2, 3, 1);
    chk("p1_beat", {16'd0, BEAT_CNT}, 19);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, (k > 15), 1, 0, 2, 3, 1);
      exp_q.push_back((k % 5) == 0);
      @(negedge ACLK);
      pop_chk("p2_sready", S_WREADY);
    end
    cyc(0, 0, 1, 0, 2, 3, 1);
    chk("p2_beat",  {16'd0, BEAT_CNT}, 23);
    chk("p2_burst", {16'd0, BURST_CNT}, 2);
    chk("p2_error", {31'd0, ERROR}, 0);

    // VALID dropped during LOW before any handshake.
    cyc(0, 0, 1, 1, 1, 5, 1);
    cyc(1, 0, 1, 0, 1, 5, 1);
    cyc(1, 0, 1, 0, 1, 5, 1);
    cyc(0, 0, 1, 0, 1, 5, 1);
    @(negedge ACLK);
    chk("err_drop_cycle", {31'd0, ERROR}, 0);
    cyc(0, 0, 1, 0, 1, 5, 1);
    @(negedge ACLK);
    chk("err_next_cycle", {31'd0, ERROR}, 1);
    repeat (4) cyc(0, 0, 1, 0, 1, 5, 1);
    chk("err_sticky", {31'd0, ERROR}, 1);

    // Reset mid-burst after 3 beats.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("pre_rst_beat", {16'd0, BEAT_CNT}, 3);
    #2 ARESETN = 1'b0; #1;
    chk("async_sready", {31'd0, S_WREADY}, 0);
    chk("async_mvalid", {31'd0, M_WVALID}, 0);
    chk("async_beat",   {16'd0, BEAT_CNT}, 0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    S_WVALID = 0; M_WREADY = 1; ARESETN = 1'b1; #1;
    chk("rel_sready", {31'd0, S_WREADY}, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    @(negedge ACLK);
    chk("resume_sready", {31'd0, S_WREADY}, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("resume_beat",  {16'd0, BEAT_CNT}, 1);
    chk("resume_error", {31'd0, ERROR}, 0);

    // HIGH=0 behaves as HIGH=1.
    cyc(0, 0, 1, 1, 1, 2, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 1, 0, 1, 2, 0);
      exp_q.push_back((k % 3) == 0);
      @(negedge ACLK);
      pop_chk("hi0_sready", S_WREADY);
    end
    // LOW=0 under oscillate keeps the gate open.
    cyc(0, 0, 1, 1, 1, 0, 4);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 0, 1, 0, 1, 0, 4);
      exp_q.push_back(1'b1);
      @(negedge ACLK);
      pop_chk("lo0_sready", S_WREADY);
    end

    // Counter wrap: 65537 beats from zero.
    do_reset();
    for (int k = 0; k < 65535; k++) cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("beat_ffff", {16'd0, BEAT_CNT}, 32'hFFFF);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("beat_wrap",  {16'd0, BEAT_CNT}, 1);
    chk("burst_wrap", {16'd0, BURST_CNT}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
